// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked RV32/RV64 instruction-decode stage.
// Each accepted word is decoded combinationally, then stored already decoded
// in a MAIN/SKID register pair. This gives a registered in_ready, full
// throughput and a single-cycle flush.
// Optional feature: define DECODE_MULDIV_EN to make OP/OP-32 funct7=0000001
// (M extension) legal and flag it through out_is_muldiv.
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. A valid source holds its payload until that edge. ready never depends
// combinationally on valid.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic            out_is_muldiv,
    output logic            out_illegal,
    output logic            out_uses_rs1,
    output logic            out_uses_rs2,
    output logic            out_writes_rd,
    output logic [1:0]      dbg_state
);

`ifdef DECODE_MULDIV_EN
    localparam logic MULDIV_EN = 1'b1;
`else
    localparam logic MULDIV_EN = 1'b0;
`endif

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_OP_32    = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;

    localparam logic       IS_RV64      = (XLEN == 64);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic            is_muldiv;
        logic            illegal;
        logic            uses_rs1;
        logic            uses_rs2;
        logic            writes_rd;
    } dec_t;

    state_t state_q, state_d;
    logic   in_ready_q, in_ready_d;
    dec_t   main_q, main_d;
    dec_t   skid_q, skid_d;
    dec_t   dec;

    logic   accept;
    logic   main_load;
    logic   main_from_skid;
    logic   skid_load;

    // Decode the incoming word: fields, sign-extended immediate, legality and register usage
    always_comb begin
        logic [6:0]  op;
        logic [31:0] imm32;
        logic        legal_op;
        logic        is_op_rr;
        logic        f7_ok;
        logic        muldiv_enc;
        logic        bad;

        op         = in_instr[6:0];
        imm32      = 32'd0;
        legal_op   = 1'b0;
        dec        = '0;

        dec.pc     = in_pc;
        dec.opcode = op;
        dec.rd     = in_instr[11:7];
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.funct3 = in_instr[14:12];
        dec.funct7 = in_instr[31:25];

        case (op)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_OP_IMM32:
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            OPC_STORE:
                imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            OPC_BRANCH:
                imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
            OPC_JAL:
                imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm32 = {in_instr[31:12], 12'd0};
            default:
                imm32 = 32'd0;
        endcase
        // Widen to XLEN by copying bit 31 into the upper bits.
        dec.imm       = {XLEN{imm32[31]}};
        dec.imm[31:0] = imm32;

        case (op)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL,
            OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_MISC_MEM, OPC_SYSTEM:
                legal_op = 1'b1;
            OPC_OP_32, OPC_OP_IMM32:
                legal_op = IS_RV64;
            default:
                legal_op = 1'b0;
        endcase

        is_op_rr   = (op == OPC_OP) || (op == OPC_OP_32);
        muldiv_enc = is_op_rr && (in_instr[31:25] == 7'b0000001);
        f7_ok      = (in_instr[31:25] == 7'b0000000) ||
                     (in_instr[31:25] == 7'b0100000) ||
                     (muldiv_enc && MULDIV_EN);

        bad = (in_instr[1:0] != 2'b11) || !legal_op ||
              (is_op_rr && !f7_ok) ||
              ((op == OPC_JALR) && (in_instr[14:12] != 3'b000));

        // An illegal word keeps its fields but reports only out_illegal.
        dec.illegal   = bad;
        dec.is_muldiv = !bad && muldiv_enc && MULDIV_EN;
        dec.uses_rs1  = !bad && !((op == OPC_LUI) || (op == OPC_AUIPC) ||
                                  (op == OPC_JAL) || (op == OPC_MISC_MEM) ||
                                  (op == OPC_SYSTEM));
        dec.uses_rs2  = !bad && ((op == OPC_OP) || (op == OPC_OP_32) ||
                                 (op == OPC_STORE) || (op == OPC_BRANCH));
        dec.writes_rd = !bad && (in_instr[11:7] != 5'd0) &&
                        !((op == OPC_STORE) || (op == OPC_BRANCH) ||
                          (op == OPC_MISC_MEM));
    end

    // Next-state and register-load control for the MAIN/SKID pair; flush overrides all
    always_comb begin
        accept         = in_valid && in_ready_q;
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_d   = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && out_ready) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_d   = ST_SKID;
                    end else if (out_ready) begin
                        state_d   = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_ready) begin
                        main_from_skid = 1'b1;
                        state_d        = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        // in_ready comes from a register: it is low exactly while SKID is occupied.
        in_ready_d = (state_d != ST_SKID);

        main_d = main_q;
        if (main_from_skid) begin
            main_d = skid_q;
        end else if (main_load) begin
            main_d = dec;
        end
        skid_d = skid_load ? dec : skid_q;
    end

    // State, ready flag and holding registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = (state_q != ST_EMPTY);
    assign out_pc        = main_q.pc;
    assign out_opcode    = main_q.opcode;
    assign out_rd        = main_q.rd;
    assign out_rs1       = main_q.rs1;
    assign out_rs2       = main_q.rs2;
    assign out_funct3    = main_q.funct3;
    assign out_funct7    = main_q.funct7;
    assign out_imm       = main_q.imm;
    assign out_is_muldiv = main_q.is_muldiv;
    assign out_illegal   = main_q.illegal;
    assign out_uses_rs1  = main_q.uses_rs1;
    assign out_uses_rs2  = main_q.uses_rs2;
    assign out_writes_rd = main_q.writes_rd;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: decode vectors, back-pressure, flush.
module tb_decode_stage;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] IMM_M4  = {XLEN{1'b1}} << 2;
    localparam logic [XLEN-1:0] IMM_LUI = {XLEN{1'b1}} << 31;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic            out_is_muldiv;
    logic            out_illegal;
    logic            out_uses_rs1;
    logic            out_uses_rs2;
    logic            out_writes_rd;
    logic [1:0]      dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [XLEN-1:0] exp_q[$];

    decode_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_is_muldiv(out_is_muldiv), .out_illegal(out_illegal),
        .out_uses_rs1(out_uses_rs1), .out_uses_rs2(out_uses_rs2),
        .out_writes_rd(out_writes_rd), .dbg_state(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        step();
        in_valid = 1'b0;
    endtask

    // Scoreboard: record accepted PCs, check every delivered PC in order
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_out", 64'(out_pc), 64'hDEAD);
                    end else begin
                        check("sb_order_pc", 64'(out_pc), 64'(exp_q.pop_front()));
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(in_pc);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_pc     = '0;
        out_ready = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;

        // Reset state
        check("rst_in_ready",  64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_state",     64'(dbg_state), 64'd0);
        check("rst_out_imm",   64'(out_imm), 64'd0);
        check("rst_out_pc",    64'(out_pc), 64'd0);
        check("rst_flags",     64'({out_illegal, out_is_muldiv, out_uses_rs1,
                                    out_uses_rs2, out_writes_rd, out_rd}), 64'd0);

        // addi x1, x0, 5
        send(32'h00500093, 'h100);
        check("addi_valid",   64'(out_valid), 64'd1);
        check("addi_pc",      64'(out_pc), 64'h100);
        check("addi_opcode",  64'(out_opcode), 64'h13);
        check("addi_imm",     64'(out_imm), 64'd5);
        check("addi_rd",      64'(out_rd), 64'd1);
        check("addi_wr_rd",   64'(out_writes_rd), 64'd1);
        check("addi_use_rs1", 64'(out_uses_rs1), 64'd1);
        check("addi_use_rs2", 64'(out_uses_rs2), 64'd0);
        check("addi_illegal", 64'(out_illegal), 64'd0);

        // beq x0, x0, -4
        send(32'hFE000EE3, 'h104);
        check("beq_imm",      64'(out_imm), 64'(IMM_M4));
        check("beq_use_rs2",  64'(out_uses_rs2), 64'd1);
        check("beq_wr_rd",    64'(out_writes_rd), 64'd0);

        // lui x1, 0x80000
        send(32'h800000B7, 'h108);
        check("lui_imm",      64'(out_imm), 64'(IMM_LUI));
        check("lui_use_rs1",  64'(out_uses_rs1), 64'd0);
        check("lui_wr_rd",    64'(out_writes_rd), 64'd1);

        // mul x10, x10, x11
        send(32'h02B50533, 'h10C);
        check("mul_rd",       64'(out_rd), 64'd10);
        check("mul_rs1",      64'(out_rs1), 64'd10);
        check("mul_rs2",      64'(out_rs2), 64'd11);
        check("mul_funct7",   64'(out_funct7), 64'd1);
`ifdef DECODE_MULDIV_EN
        check("mul_is_muldiv", 64'(out_is_muldiv), 64'd1);
        check("mul_illegal",   64'(out_illegal), 64'd0);
`else
        check("mul_is_muldiv", 64'(out_is_muldiv), 64'd0);
        check("mul_illegal",   64'(out_illegal), 64'd1);
        check("mul_wr_rd",     64'(out_writes_rd), 64'd0);
`endif

        // Unsupported opcode
        send(32'h0000007F, 'h110);
        check("op7f_illegal", 64'(out_illegal), 64'd1);

        // OP-32 add x0,x0,x0: legal only on RV64
        send(32'h0000003B, 'h114);
        check("op32_illegal", 64'(out_illegal), 64'((XLEN == 32) ? 1 : 0));

        // JALR with funct3=001
        send(32'h00001067, 'h118);
        check("jalr_f3_illegal", 64'(out_illegal), 64'd1);
        check("jalr_f3_use_rs1", 64'(out_uses_rs1), 64'd0);

        // addi x0, x0, 0: rd=0 never writes
        send(32'h00000013, 'h11C);
        check("nop_wr_rd",    64'(out_writes_rd), 64'd1 - 64'd1);
        check("nop_illegal",  64'(out_illegal), 64'd0);
        step();
        check("drain_valid",  64'(out_valid), 64'd0);

        // Back-pressure: 4 instructions, out_ready low for 3 cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        in_pc     = 'h200;
        step();
        check("bp_ready_1",   64'(in_ready), 64'd1);
        check("bp_pc_a",      64'(out_pc), 64'h200);
        in_pc = 'h204;
        step();
        check("bp_ready_drop", 64'(in_ready), 64'd0);
        check("bp_state_skid", 64'(dbg_state), 64'd2);
        in_pc = 'h208;
        step();
        check("bp_hold_pc",   64'(out_pc), 64'h200);
        check("bp_hold_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step();
        check("bp_pc_b",      64'(out_pc), 64'h204);
        check("bp_ready_back", 64'(in_ready), 64'd1);
        step();
        check("bp_pc_c",      64'(out_pc), 64'h208);
        in_pc = 'h20C;
        step();
        check("bp_pc_d",      64'(out_pc), 64'h20C);
        in_valid = 1'b0;
        step();
        check("bp_empty",     64'(out_valid), 64'd0);

        // Flush while SKID is occupied and a new word is offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 'h300;
        step();
        in_pc = 'h304;
        step();
        check("fl_state_skid", 64'(dbg_state), 64'd2);
        flush = 1'b1;
        in_pc = 'h308;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_valid",     64'(out_valid), 64'd0);
        check("fl_ready",     64'(in_ready), 64'd1);
        check("fl_state",     64'(dbg_state), 64'd0);
        out_ready = 1'b1;
        step();
        step();
        check("fl_stay_empty", 64'(out_valid), 64'd0);
        send(32'h00500093, 'h400);
        check("fl_after_pc",  64'(out_pc), 64'h400);
        step();
        check("fl_after_empty", 64'(out_valid), 64'd0);
        check("sb_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
